// File: rtl/four_bit_adder_pkg.sv
// Shared types and defaults for the four_bit_adder block.
package four_bit_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] operand_t;

    typedef struct packed {
        operand_t sum;
        logic     cout;
        logic     ovf;
    } result_t;

endpackage

// File: rtl/four_bit_adder_full_adder_bit.sv
// Single-bit full adder used as the ripple stage and as the sum cell of the CLA build.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/four_bit_adder.sv
// A + B + C0 with combinational sum/carry and a one-cycle registered copy plus overflow.
// Define FOUR_BIT_ADDER_CLA_EN to select carry-lookahead and expose PG/GG.
module four_bit_adder
    import four_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic [WIDTH-1:0] S,
    output logic             C4,
    output logic [WIDTH-1:0] S_R,
    output logic             C4_R,
    output logic             V_R
`ifdef FOUR_BIT_ADDER_CLA_EN
    ,
    output logic             PG,
    output logic             GG
`endif
);

    logic [WIDTH:0] c;

`ifdef FOUR_BIT_ADDER_CLA_EN
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] unused_co;

    assign p = A ^ B;
    assign g = A & B;

    // Each carry is an independent sum-of-products; loops only unroll the terms.
    always_comb begin
        logic prop;
        logic term;
        logic grp;
        c    = '0;
        c[0] = C0;
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            prop = C0;
            for (int unsigned k = 0; k < i; k++) prop = prop & p[k];
            c[i] = prop;
            for (int unsigned j = 0; j < i; j++) begin
                term = g[j];
                for (int unsigned k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        grp = 1'b0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            term = g[j];
            for (int unsigned k = j + 1; k < WIDTH; k++) term = term & p[k];
            grp = grp | term;
        end
        GG = grp;
    end

    assign PG = &p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        full_adder_bit u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (unused_co[i])
        );
    end
`else
    assign c[0] = C0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder_bit u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end
`endif

    assign C4 = c[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_R  <= '0;
            C4_R <= 1'b0;
            V_R  <= 1'b0;
        end else begin
            S_R  <= S;
            C4_R <= C4;
            V_R  <= c[WIDTH-1] ^ c[WIDTH];
        end
    end

endmodule

// File: tb/tb_four_bit_adder.sv
// Randomized self-checking bench for four_bit_adder against an arithmetic reference model.
module tb_four_bit_adder;
    import four_bit_adder_pkg::*;

    logic     clk;
    logic     rst;
    operand_t A;
    operand_t B;
    logic     C0;
    operand_t S;
    logic     C4;
    operand_t S_R;
    logic     C4_R;
    logic     V_R;
`ifdef FOUR_BIT_ADDER_CLA_EN
    logic     PG;
    logic     GG;
`endif

    int checks;
    int failures;

    four_bit_adder #(.WIDTH(ADDER_WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .C0   (C0),
        .S    (S),
        .C4   (C4),
        .S_R  (S_R),
        .C4_R (C4_R),
        .V_R  (V_R)
`ifdef FOUR_BIT_ADDER_CLA_EN
        ,
        .PG   (PG),
        .GG   (GG)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition, and signed range test for overflow.
    function automatic result_t model(input operand_t a, input operand_t b, input logic ci);
        result_t r;
        int unsigned total;
        int sa;
        int sb;
        int ssum;
        total  = int'(a) + int'(b) + int'(ci);
        r.sum  = operand_t'(total % 16);
        r.cout = (total >= 16);
        sa     = (a >= 8) ? int'(a) - 16 : int'(a);
        sb     = (b >= 8) ? int'(b) - 16 : int'(b);
        ssum   = sa + sb + int'(ci);
        r.ovf  = (ssum > 7) || (ssum < -8);
        return r;
    endfunction

    task automatic check_comb(input string tag);
        result_t e;
        e = model(A, B, C0);
        check_eq({tag, "_S"}, S, e.sum);
        check_eq({tag, "_C4"}, C4, e.cout);
`ifdef FOUR_BIT_ADDER_CLA_EN
        check_eq({tag, "_GGPG"}, C4, GG | (PG & C0));
`endif
    endtask

    task automatic check_reg(input string tag, input result_t e);
        check_eq({tag, "_S_R"}, S_R, e.sum);
        check_eq({tag, "_C4_R"}, C4_R, e.cout);
        check_eq({tag, "_V_R"}, V_R, e.ovf);
    endtask

    // Drive at negedge, check comb, then check capture after the next rising edge.
    task automatic apply(input string tag, input operand_t a, input operand_t b, input logic ci);
        result_t e;
        @(negedge clk);
        A  = a;
        B  = b;
        C0 = ci;
        #1;
        check_comb(tag);
        e = model(a, b, ci);
        @(posedge clk);
        #1;
        check_reg(tag, e);
    endtask

    initial begin
        result_t zero;
        int unsigned order [512];
        checks   = 0;
        failures = 0;
        zero     = '0;

        // Reset held with inputs toggling
        rst = 1'b1;
        A   = '0;
        B   = '0;
        C0  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            A  = operand_t'($urandom_range(15));
            B  = operand_t'($urandom_range(15));
            C0 = 1'(($urandom_range(1)));
            #2;
            check_comb("rst_comb");
            check_reg("rst_hold", zero);
        end
        @(negedge clk);
        check_reg("rst_hold_end", zero);
        rst = 1'b0;

        apply("dir_3_5", 4'b0011, 4'b0101, 1'b0);
        apply("dir_f_f_1", 4'b1111, 4'b1111, 1'b1);
        apply("dir_wrap", 4'b1111, 4'b0000, 1'b1);
        apply("dir_zero", 4'b0000, 4'b0000, 1'b0);

        // Mid-operation reset between edges, with changed inputs while held
        apply("pre_rst", 4'b0011, 4'b0101, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        A   = 4'b0001;
        B   = 4'b0001;
        C0  = 1'b0;
        #1;
        check_reg("mid_rst_async", zero);
        @(posedge clk);
        #1;
        check_reg("mid_rst_edge", zero);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reg("post_rel_pre_edge", zero);
        @(posedge clk);
        #1;
        check_reg("first_capture", model(4'b0001, 4'b0001, 1'b0));

        // Exhaustive sweep in shuffled order
        for (int unsigned i = 0; i < 512; i++) order[i] = i;
        for (int unsigned i = 511; i > 0; i--) begin
            int unsigned j;
            int unsigned t;
            j        = $urandom_range(i);
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int unsigned i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(order[i]);
            apply("exh", v[8:5], v[4:1], v[0]);
        end

        // Random back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            apply("rnd", operand_t'($urandom_range(15)), operand_t'($urandom_range(15)),
                  1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
